hazard_forward_unit: RTL and testbench

//  Parametrised successor of the EX-stage forwarding unit. Tracks in-flight register writers in a

---
 rtl/hazard_forward_unit_if.sv | 40 ++++
 rtl/hazard_forward_unit.sv | 155 +++++++++++++++
 tb/tb_hazard_forward_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - ID-stage operand bus between decode and the hazard/forward unit
//
// Purpose: carries the decoded ID instruction fields to the hazard/forward
// unit and returns its stall request and the registered EX forwarding selects.
// Ports (signals):
//   id_valid     decode -> unit  ID holds a real instruction
//   id_rs        decode -> unit  NUM_SRC packed source indices, source i at [i*REG_AW +: REG_AW]
//   id_rs_used   decode -> unit  source i is actually read
//   id_rd        decode -> unit  destination index
//   id_regwrite  decode -> unit  instruction writes rd
//   id_memread   decode -> unit  instruction is a load
//   stall_id     unit -> decode  load-use hazard, hold PC and IF/ID
//   ex_fwd_sel   unit -> EX      per-source select, 0=regfile, k=forward from stage k
// Modports: master = decode side, slave = hazard/forward unit.
interface hazard_forward_unit_if #(
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2
);
  localparam int SEL_W = $clog2(FWD_STAGES + 1);

  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_regwrite;
  logic                      id_memread;
  logic                      stall_id;
  logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread,
    input  stall_id, ex_fwd_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread,
    output stall_id, ex_fwd_sel
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - ID-stage forwarding resolver and load-use stall generator
//
// Purpose: shadows the in-flight register writers after ID, resolves operand
// forwarding one cycle early and registers the selects into EX; raises a
// load-use stall when a source depends on a load that cannot yet forward.
// Optional feature macro: HAZARD_STATS_EN (adds stall/forward counters).
// Ports:
//   clk_i          clock
//   reset_i        synchronous active-high reset, discards all in-flight state
//   pipe_hold_i    global freeze, all state held
//   flush_i        discard the ID instruction (it becomes a bubble, never stalls)
//   id_if          slave side of hazard_forward_unit_if (ID fields in, stall/selects out)
//   stat_stalls_o  (HAZARD_STATS_EN) cycles with stall_id while advancing
//   stat_fwds_o    (HAZARD_STATS_EN) entering sources with a nonzero select
module hazard_forward_unit #(
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 pipe_hold_i,
  input  logic                 flush_i,
  hazard_forward_unit_if.slave id_if
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          stat_stalls_o,
  output logic [31:0]          stat_fwds_o
`endif
);

  // Shadow pipeline: entry 1 mirrors EX, entry k is k stages past ID.
  logic              t_valid_q    [1:FWD_STAGES];
  logic [REG_AW-1:0] t_rd_q       [1:FWD_STAGES];
  logic              t_regwrite_q [1:FWD_STAGES];
  logic              t_memread_q  [1:FWD_STAGES];
  logic              t_valid_d    [1:FWD_STAGES];
  logic [REG_AW-1:0] t_rd_d       [1:FWD_STAGES];
  logic              t_regwrite_d [1:FWD_STAGES];
  logic              t_memread_d  [1:FWD_STAGES];

  logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel_q;
  logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel_d;

  logic [NUM_SRC*SEL_W-1:0] sel_calc;
  logic [NUM_SRC-1:0]       load_hit;
  logic                     stall;
  logic                     advance;
  logic                     enter;

  // Walk from oldest to youngest so the youngest matching writer overwrites
  // older ones. A load only hazards if it is still too young to forward.
  always_comb begin
    sel_calc = '0;
    load_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (id_if.id_rs_used[i] && t_valid_q[k] && t_regwrite_q[k] &&
            (t_rd_q[k] != '0) &&
            (t_rd_q[k] == id_if.id_rs[i*REG_AW +: REG_AW])) begin
          sel_calc[i*SEL_W +: SEL_W] = SEL_W'(k);
          load_hit[i]                = t_memread_q[k] && (k < LOAD_STAGE);
        end
      end
    end
  end

  assign stall   = id_if.id_valid && !flush_i && (|load_hit);
  assign advance = !pipe_hold_i;
  assign enter   = id_if.id_valid && !stall && !flush_i;

  always_comb begin
    for (int k = 1; k <= FWD_STAGES; k++) begin
      t_valid_d[k]    = t_valid_q[k];
      t_rd_d[k]       = t_rd_q[k];
      t_regwrite_d[k] = t_regwrite_q[k];
      t_memread_d[k]  = t_memread_q[k];
    end
    ex_fwd_sel_d = ex_fwd_sel_q;
    if (advance) begin
      for (int k = FWD_STAGES; k >= 2; k--) begin
        t_valid_d[k]    = t_valid_q[k-1];
        t_rd_d[k]       = t_rd_q[k-1];
        t_regwrite_d[k] = t_regwrite_q[k-1];
        t_memread_d[k]  = t_memread_q[k-1];
      end
      // A stalled or flushed ID inserts a bubble; its fields are don't-care.
      t_valid_d[1]    = enter;
      t_rd_d[1]       = id_if.id_rd;
      t_regwrite_d[1] = id_if.id_regwrite;
      t_memread_d[1]  = id_if.id_memread;
      ex_fwd_sel_d    = enter ? sel_calc : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        t_valid_q[k]    <= 1'b0;
        t_rd_q[k]       <= '0;
        t_regwrite_q[k] <= 1'b0;
        t_memread_q[k]  <= 1'b0;
      end
      ex_fwd_sel_q <= '0;
    end else begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        t_valid_q[k]    <= t_valid_d[k];
        t_rd_q[k]       <= t_rd_d[k];
        t_regwrite_q[k] <= t_regwrite_d[k];
        t_memread_q[k]  <= t_memread_d[k];
      end
      ex_fwd_sel_q <= ex_fwd_sel_d;
    end
  end

  assign id_if.stall_id   = stall;
  assign id_if.ex_fwd_sel = ex_fwd_sel_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stalls_q;
  logic [31:0] stat_stalls_d;
  logic [31:0] stat_fwds_q;
  logic [31:0] stat_fwds_d;
  logic [31:0] fwd_cnt;

  always_comb begin
    fwd_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_calc[i*SEL_W +: SEL_W] != '0) fwd_cnt = fwd_cnt + 32'd1;
    end
    stat_stalls_d = stat_stalls_q;
    stat_fwds_d   = stat_fwds_q;
    if (advance) begin
      if (stall) stat_stalls_d = stat_stalls_q + 32'd1;
      if (enter) stat_fwds_d   = stat_fwds_q + fwd_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_stalls_q <= '0;
      stat_fwds_q   <= '0;
    end else begin
      stat_stalls_q <= stat_stalls_d;
      stat_fwds_q   <= stat_fwds_d;
    end
  end

  assign stat_stalls_o = stat_stalls_q;
  assign stat_fwds_o   = stat_fwds_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - scoreboard bench for hazard_forward_unit in two configurations
module tb_hazard_forward_unit;
  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [14:0] id_rs = '0;
  logic [2:0]  id_used = '0;
  logic [4:0]  id_rd = '0;
  logic        id_rw = 1'b0;
  logic        id_mr = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         which;
    bit         chk;
    bit         stall;
    logic [5:0] sel;
    int         tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.NUM_SRC(2), .REG_AW(5), .FWD_STAGES(2)) ifa ();
  hazard_forward_unit_if #(.NUM_SRC(3), .REG_AW(5), .FWD_STAGES(3)) ifb ();

  assign ifa.id_valid    = id_valid;
  assign ifa.id_rs       = id_rs[9:0];
  assign ifa.id_rs_used  = id_used[1:0];
  assign ifa.id_rd       = id_rd;
  assign ifa.id_regwrite = id_rw;
  assign ifa.id_memread  = id_mr;
  assign ifb.id_valid    = id_valid;
  assign ifb.id_rs       = id_rs;
  assign ifb.id_rs_used  = id_used;
  assign ifb.id_rd       = id_rd;
  assign ifb.id_regwrite = id_rw;
  assign ifb.id_memread  = id_mr;

`ifdef HAZARD_STATS_EN
  logic [31:0] sa_stalls, sa_fwds, sb_stalls, sb_fwds;
`endif

  hazard_forward_unit #(.NUM_SRC(2), .REG_AW(5), .FWD_STAGES(2), .LOAD_STAGE(2)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .pipe_hold_i(hold), .flush_i(flush), .id_if(ifa.slave)
`ifdef HAZARD_STATS_EN
    , .stat_stalls_o(sa_stalls), .stat_fwds_o(sa_fwds)
`endif
  );

  hazard_forward_unit #(.NUM_SRC(3), .REG_AW(5), .FWD_STAGES(3), .LOAD_STAGE(2)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .pipe_hold_i(hold), .flush_i(flush), .id_if(ifb.slave)
`ifdef HAZARD_STATS_EN
    , .stat_stalls_o(sb_stalls), .stat_fwds_o(sb_fwds)
`endif
  );

  function automatic logic [14:0] rs3(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    return {r2, r1, r0};
  endfunction

  int vec_no = 0;

  // Applies one cycle of inputs just after the edge and queues what the
  // selected DUT must show for that cycle (stall now, selects from last advance).
  task automatic step(input bit w, input bit chk, input bit rst, input bit hd, input bit fl,
                      input bit v, input logic [14:0] rs, input logic [2:0] used,
                      input logic [4:0] rd, input bit rw, input bit mr,
                      input bit es, input logic [5:0] esel);
    exp_t e;
    @(posedge clk);
    #1;
    rst_a    = w ? 1'b1 : rst;
    rst_b    = w ? rst : 1'b1;
    hold     = hd;
    flush    = fl;
    id_valid = v;
    id_rs    = rs;
    id_used  = used;
    id_rd    = rd;
    id_rw    = rw;
    id_mr    = mr;
    e.which  = w;
    e.chk    = chk;
    e.stall  = es;
    e.sel    = esel;
    e.tag    = vec_no;
    vec_no++;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic       act_stall;
      logic [5:0] act_sel;
      e = exp_q.pop_front();
      if (e.which) begin
        act_stall = ifb.stall_id;
        act_sel   = ifb.ex_fwd_sel;
      end else begin
        act_stall = ifa.stall_id;
        act_sel   = {2'b00, ifa.ex_fwd_sel};
      end
      if (e.chk) begin
        checks++;
        if (act_stall !== e.stall) begin
          errors++;
          $display("FAIL stall_id dut%0d vec%0d: got %b expected %b", e.which, e.tag, act_stall, e.stall);
        end
        checks++;
        if (act_sel !== e.sel) begin
          errors++;
          $display("FAIL ex_fwd_sel dut%0d vec%0d: got %b expected %b", e.which, e.tag, act_sel, e.sel);
        end
      end
    end
  end

  initial begin
    // ---------------- configuration A: NUM_SRC=2, FWD_STAGES=2 ----------------
    //   w  chk rst hd fl  v  rs                 used  rd     rw mr  stall sel
    step(0, 0, 1, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b000000);
    // EX-EX forward of x5 into src0
    step(0, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd5,  1, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 1, rs3(5, 0, 0),    3'b001, 5'd6,  1, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b000001);
    // x7 in t1 and t2: youngest wins (code 1), then t2 only gives code 2
    step(0, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd7,  1, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd7,  1, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 1, rs3(0, 7, 0),    3'b010, 5'd9,  0, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 1, rs3(7, 0, 0),    3'b001, 5'd0,  0, 0, 0, 6'b000100);
    // load-use on x3: one stall cycle, then forward from stage 2
    step(0, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd3,  1, 1, 0, 6'b000010);
    step(0, 1, 0, 0, 0, 1, rs3(3, 0, 0),    3'b001, 5'd4,  1, 0, 1, 6'b000000);
    step(0, 1, 0, 0, 0, 1, rs3(3, 0, 0),    3'b001, 5'd4,  1, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b000010);
    // x0 never forwards/stalls; unused sources ignore a pending load
    step(0, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd0,  1, 1, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b001, 5'd8,  1, 1, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 1, rs3(8, 8, 0),    3'b000, 5'd0,  0, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b000000);
    // pipe_hold for 3 cycles freezes shadow state and selects
    step(0, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd10, 1, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 1, rs3(10, 0, 0),   3'b001, 5'd0,  0, 0, 0, 6'b000000);
    step(0, 1, 0, 1, 0, 1, rs3(0, 10, 0),   3'b010, 5'd0,  0, 0, 0, 6'b000001);
    step(0, 1, 0, 1, 0, 1, rs3(0, 10, 0),   3'b010, 5'd0,  0, 0, 0, 6'b000001);
    step(0, 1, 0, 1, 0, 1, rs3(0, 10, 0),   3'b010, 5'd0,  0, 0, 0, 6'b000001);
    step(0, 1, 0, 0, 0, 1, rs3(0, 10, 0),   3'b010, 5'd0,  0, 0, 0, 6'b000001);
    // flush beats a load-use hazard and the flushed writer never enters
    step(0, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd11, 1, 1, 0, 6'b001000);
    step(0, 1, 0, 0, 1, 1, rs3(11, 0, 0),   3'b001, 5'd12, 1, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 1, rs3(12, 0, 0),   3'b001, 5'd0,  0, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b000000);
    // reset with a load in t1 discards it
    step(0, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd13, 1, 1, 0, 6'b000000);
    step(0, 1, 1, 0, 0, 1, rs3(13, 0, 0),   3'b001, 5'd0,  0, 0, 1, 6'b000000);
    step(0, 1, 0, 0, 0, 1, rs3(13, 0, 0),   3'b001, 5'd0,  0, 0, 0, 6'b000000);
    step(0, 1, 0, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b000000);

    // ---------------- configuration B: NUM_SRC=3, FWD_STAGES=3 ----------------
    step(1, 0, 1, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b000000);
    step(1, 1, 0, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b000000);
    // x5 forwarded from stages 1, 2, 3 into src2, src0, src1
    step(1, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd5,  1, 0, 0, 6'b000000);
    step(1, 1, 0, 0, 0, 1, rs3(0, 0, 5),    3'b100, 5'd0,  0, 0, 0, 6'b000000);
    step(1, 1, 0, 0, 0, 1, rs3(5, 0, 0),    3'b001, 5'd0,  0, 0, 0, 6'b010000);
    step(1, 1, 0, 0, 0, 1, rs3(0, 5, 0),    3'b010, 5'd0,  0, 0, 0, 6'b000010);
    step(1, 1, 0, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b001100);
    // priority with all three sources reading x7
    step(1, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd7,  1, 0, 0, 6'b000000);
    step(1, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd7,  1, 0, 0, 6'b000000);
    step(1, 1, 0, 0, 0, 1, rs3(7, 7, 7),    3'b111, 5'd0,  0, 0, 0, 6'b000000);
    step(1, 1, 0, 0, 0, 1, rs3(0, 7, 0),    3'b010, 5'd0,  0, 0, 0, 6'b010101);
    step(1, 1, 0, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b001000);
    // load-use on src2
    step(1, 1, 0, 0, 0, 1, rs3(0, 0, 0),    3'b000, 5'd3,  1, 1, 0, 6'b000000);
    step(1, 1, 0, 0, 0, 1, rs3(0, 0, 3),    3'b100, 5'd4,  1, 0, 1, 6'b000000);
    step(1, 1, 0, 0, 0, 1, rs3(0, 0, 3),    3'b100, 5'd4,  1, 0, 0, 6'b000000);
    step(1, 1, 0, 0, 0, 0, rs3(0, 0, 0),    3'b000, 5'd0,  0, 0, 0, 6'b100000);

    begin
      int budget;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      @(posedge clk);
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
